framebuffer_write_scheduler: RTL and testbench
==============================================

Name: framebuffer_write_scheduler

Overview:
- Owns the single write port of the double-buffered framebuffer RAM.
- Arbitrates between byte writes from the UART command path and an internal clear/fill sequencer.
- Always targets the back buffer.
- Performs the front/back buffer swap only at a frame boundary, and only when no clear is in progress.

Parameters:
ADDR_WIDTH, 12, per-bank RAM address width (bank holds 2^ADDR_WIDTH bytes)
DATA_WIDTH, 8, RAM data width

Ports:
clk_in  input  1  system clock; all logic posedge
reset  input  1  asynchronous, active-high
wr_req  input  1  command-path write strobe, one-cycle pulse
wr_addr  input  ADDR_WIDTH  command-path byte address within bank
wr_data  input  DATA_WIDTH  command-path byte
clear_start  input  1  pulse; fill entire back bank with clear_value
clear_value  input  DATA_WIDTH  fill byte, sampled on accepted clear_start
swap_req  input  1  pulse; request buffer swap
frame_end  input  1  pulse from scan logic at end of displayed frame
ram_address  output  ADDR_WIDTH+1  {bank, address}; bank = ~active_buffer
ram_data_out  output  DATA_WIDTH  write data
ram_write_enable  output  1  write strobe to RAM
active_buffer  output  1  bank currently displayed
swap_pending  output  1  swap requested, not yet performed
clear_busy  output  1  sequencer in CLEAR state
cmd_write_count  output  8  wrapping count of command writes issued

Behaviour:
- Reset values (asynchronous reset, and also on reset mid-operation): all outputs 0. State IDLE. Fill counter 0. Any in-progress clear is aborted; no partial-write recovery.
- RAM port timing: the port is registered. A write selected in cycle N appears on ram_address/ram_data_out with ram_write_enable=1 in cycle N+1. In any cycle with no selected write, ram_write_enable=0 next cycle; address and data hold their last values.
- Priority: wr_req always wins (the UART path cannot stall) and is never dropped.
  - Command write: ram_address = {~active_buffer, wr_addr}; cmd_write_count increments, wrapping 255->0.
- Sequencer states:
  - IDLE: on clear_start, latch clear_value, set fill counter to 0, go to CLEAR. clear_busy=1 from the next cycle.
  - CLEAR: each cycle without wr_req, write {~active_buffer, counter} with the latched value, then increment the counter. A cycle with wr_req stalls the counter, with no skipped or duplicated address. After writing address 2^ADDR_WIDTH-1, return to IDLE; clear_busy drops the cycle after that write is selected.
  - clear_start while in CLEAR: ignored, with no restart and no new value latched.
- Swap:
  - swap_req sets swap_pending.
  - On a cycle where frame_end=1, swap_pending (or swap_req in that same cycle) is true, and state is IDLE: toggle active_buffer and clear swap_pending.
  - If state is CLEAR at frame_end, the swap stays pending until the first frame_end after the clear completes.
  - Repeated swap_req while pending: no additional effect (one swap only).
  - frame_end alone with nothing pending: no effect.
- Bank consistency:
  - A write selected in the same cycle as a swap uses the pre-swap ~active_buffer.
  - Since a swap cannot occur during CLEAR, a clear never spans both banks.
- Widths: the fill counter is ADDR_WIDTH+1 bits internally so the terminal condition is unambiguous. The bank bit is MSB of ram_address.

Decomposition:
- Shared package holds:
  - sequencer state enum (IDLE, CLEAR)
  - default ADDR_WIDTH/DATA_WIDTH constants
  - bank-bit index constant, shared with the scan read side
- One natural sub-module: framebuffer_clear_sequencer. It contains the state, fill counter, latched value, stall input and write-request output.
- The top level keeps the arbitration mux, output registers, swap logic and counters.

Test Plan:
- After reset: single wr_req, addr 0x123, data 0xA5 -> next cycle ram_address=0x1123, ram_data_out=0xA5, ram_write_enable=1, cmd_write_count=1; following cycle write_enable=0.
- clear_start with value 0x3C, ADDR_WIDTH=4 override, no other traffic -> 16 consecutive writes to 0x10..0x1F of 0x3C; clear_busy high exactly during the fill; then IDLE.
- Same clear with wr_req (addr 0x7, data 0xFF) injected at fill address 5 -> command write appears in that slot, fill resumes at 5, all 16 fill addresses written exactly once, total 17 writes.
- swap_req issued during the clear, frame_end pulses mid-clear and after completion -> no toggle mid-clear; active_buffer 0->1 at the first post-clear frame_end; swap_pending cleared; subsequent writes use bank 0.
- swap_req and frame_end in the same cycle while IDLE -> active_buffer toggles that cycle and swap_pending never observed high; three swap_req pulses before one frame_end -> exactly one toggle.
- reset asserted at fill address 9 -> immediately IDLE, clear_busy=0, active_buffer=0, ram_write_enable=0; a new clear_start restarts from address 0.

Source files
------------

// File: rtl/framebuffer_write_scheduler_pkg.sv
// Shared definitions for the framebuffer write scheduler and the scan read side.
package framebuffer_write_scheduler_pkg;

    // Default geometry: each bank holds 2^12 bytes of 8 bits.
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // The bank select bit sits directly above the per-bank address bits.
    localparam int BANK_BIT_INDEX = DEFAULT_ADDR_WIDTH;

    // Clear/fill sequencer states.
    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_CLEAR = 1'b1
    } seq_state_t;

    // Bank bit position for a non-default per-bank address width.
    function automatic int bank_bit_index(input int addr_width);
        return addr_width;
    endfunction

endpackage

// File: rtl/framebuffer_write_scheduler_clear_sequencer.sv
// Clear/fill sequencer: walks every byte of the back bank once with a latched
// fill value. The command path may stall it for any number of cycles; a stalled
// cycle neither skips nor repeats an address.
module framebuffer_clear_sequencer
    import framebuffer_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_value,
    input  logic                  stall,
    output logic                  busy,
    output logic                  fill_req,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data
);

    // One past the last bank address; the extra counter bit makes it distinct
    // from address 0.
    localparam logic [ADDR_WIDTH:0] FILL_END = {1'b1, {ADDR_WIDTH{1'b0}}};

    seq_state_t            state_q,   state_d;
    logic [ADDR_WIDTH:0]   counter_q, counter_d;
    logic [DATA_WIDTH-1:0] value_q,   value_d;
    logic [ADDR_WIDTH:0]   counter_inc;

    assign counter_inc = counter_q + 1'b1;

    // Next-state: start only from IDLE, advance only on unstalled CLEAR cycles.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        value_d   = value_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d   = SEQ_CLEAR;
                    counter_d = '0;
                    value_d   = start_value;
                end
            end
            SEQ_CLEAR: begin
                if (!stall) begin
                    counter_d = counter_inc;
                    if (counter_inc == FILL_END) begin
                        state_d = SEQ_IDLE;
                    end
                end
            end
        endcase
    end

    // State, fill counter and latched value registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            counter_q <= '0;
            value_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            value_q   <= value_d;
        end
    end

    assign busy      = (state_q == SEQ_CLEAR);
    assign fill_req  = busy;
    assign fill_addr = counter_q[ADDR_WIDTH-1:0];
    assign fill_data = value_q;

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Owns the single registered write port of the double-buffered framebuffer.
// Command writes always win over the clear sequencer; all writes target the
// back bank; the front/back swap happens only at frame_end while not clearing.
module framebuffer_write_scheduler
    import framebuffer_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    input  logic                  swap_req,
    input  logic                  frame_end,
    output logic [ADDR_WIDTH:0]   ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_write_enable,
    output logic                  active_buffer,
    output logic                  swap_pending,
    output logic                  clear_busy,
    output logic [7:0]            cmd_write_count
);

    localparam int BANK_BIT = bank_bit_index(ADDR_WIDTH);

    logic                  seq_busy;
    logic                  fill_req;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_sel;
    logic                  swap_fire;

    logic [ADDR_WIDTH:0]   ram_address_q,      ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_out_q,     ram_data_out_d;
    logic                  ram_write_enable_q, ram_write_enable_d;
    logic                  active_buffer_q,    active_buffer_d;
    logic                  swap_pending_q,     swap_pending_d;
    logic [7:0]            cmd_write_count_q,  cmd_write_count_d;

    // The command path stalls the sequencer so its slot is taken, not lost.
    framebuffer_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clear_sequencer (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (clear_start),
        .start_value (clear_value),
        .stall       (wr_req),
        .busy        (seq_busy),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data)
    );

    assign fill_sel = fill_req & ~wr_req;

    // Write-port mux: command first, then fill; address/data hold when idle.
    // The bank bit uses the pre-swap active buffer even if a swap fires now.
    always_comb begin
        ram_address_d      = ram_address_q;
        ram_data_out_d     = ram_data_out_q;
        ram_write_enable_d = 1'b0;
        cmd_write_count_d  = cmd_write_count_q;
        if (wr_req) begin
            ram_address_d[ADDR_WIDTH-1:0] = wr_addr;
            ram_address_d[BANK_BIT]       = ~active_buffer_q;
            ram_data_out_d                = wr_data;
            ram_write_enable_d            = 1'b1;
            cmd_write_count_d             = cmd_write_count_q + 8'd1;
        end else if (fill_sel) begin
            ram_address_d[ADDR_WIDTH-1:0] = fill_addr;
            ram_address_d[BANK_BIT]       = ~active_buffer_q;
            ram_data_out_d                = fill_data;
            ram_write_enable_d            = 1'b1;
        end
    end

    // Swap bookkeeping: a request (new or pending) fires at frame_end only
    // while the sequencer is idle, so a clear never straddles both banks.
    always_comb begin
        swap_fire       = frame_end & (swap_pending_q | swap_req) & ~seq_busy;
        active_buffer_d = active_buffer_q ^ swap_fire;
        swap_pending_d  = swap_pending_q;
        if (swap_fire) begin
            swap_pending_d = 1'b0;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    // Output and swap-state registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ram_address_q      <= '0;
            ram_data_out_q     <= '0;
            ram_write_enable_q <= 1'b0;
            active_buffer_q    <= 1'b0;
            swap_pending_q     <= 1'b0;
            cmd_write_count_q  <= '0;
        end else begin
            ram_address_q      <= ram_address_d;
            ram_data_out_q     <= ram_data_out_d;
            ram_write_enable_q <= ram_write_enable_d;
            active_buffer_q    <= active_buffer_d;
            swap_pending_q     <= swap_pending_d;
            cmd_write_count_q  <= cmd_write_count_d;
        end
    end

    assign ram_address      = ram_address_q;
    assign ram_data_out     = ram_data_out_q;
    assign ram_write_enable = ram_write_enable_q;
    assign active_buffer    = active_buffer_q;
    assign swap_pending     = swap_pending_q;
    assign clear_busy       = seq_busy;
    assign cmd_write_count  = cmd_write_count_q;

endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Bench for framebuffer_write_scheduler: a full-width instance for the address
// layout check and a 4-bit-address instance driven by directed and random
// steps against a transaction-level reference model and a RAM image.
module tb_framebuffer_write_scheduler;

    localparam int SAW   = 4;
    localparam int DEPTH = 1 << SAW;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset;

    // Narrow instance signals
    logic           wr_req;
    logic [SAW-1:0] wr_addr;
    logic [7:0]     wr_data;
    logic           clear_start;
    logic [7:0]     clear_value;
    logic           swap_req;
    logic           frame_end;
    logic [SAW:0]   ram_address;
    logic [7:0]     ram_data_out;
    logic           ram_write_enable, active_buffer, swap_pending, clear_busy;
    logic [7:0]     cmd_write_count;

    // Full-width instance signals
    logic           b_wr_req;
    logic [11:0]    b_wr_addr;
    logic [7:0]     b_wr_data;
    logic [12:0]    b_ram_address;
    logic [7:0]     b_ram_data_out;
    logic           b_ram_write_enable, b_active_buffer, b_swap_pending, b_clear_busy;
    logic [7:0]     b_cmd_write_count;

    framebuffer_write_scheduler #(.ADDR_WIDTH(SAW), .DATA_WIDTH(8)) dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .clear_start      (clear_start),
        .clear_value      (clear_value),
        .swap_req         (swap_req),
        .frame_end        (frame_end),
        .ram_address      (ram_address),
        .ram_data_out     (ram_data_out),
        .ram_write_enable (ram_write_enable),
        .active_buffer    (active_buffer),
        .swap_pending     (swap_pending),
        .clear_busy       (clear_busy),
        .cmd_write_count  (cmd_write_count)
    );

    framebuffer_write_scheduler dut_wide (
        .clk_in           (clk_in),
        .reset            (reset),
        .wr_req           (b_wr_req),
        .wr_addr          (b_wr_addr),
        .wr_data          (b_wr_data),
        .clear_start      (1'b0),
        .clear_value      (8'h00),
        .swap_req         (1'b0),
        .frame_end        (1'b0),
        .ram_address      (b_ram_address),
        .ram_data_out     (b_ram_data_out),
        .ram_write_enable (b_ram_write_enable),
        .active_buffer    (b_active_buffer),
        .swap_pending     (b_swap_pending),
        .clear_busy       (b_clear_busy),
        .cmd_write_count  (b_cmd_write_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    bit verbose = 1'b1;

    // Reference model: transaction-level view of the scheduler
    bit         m_active, m_pending, m_clearing, m_we;
    int         m_next;
    logic [7:0] m_val, m_count, m_data;
    logic [SAW:0] m_addr;
    logic [7:0] exp_mem [2*DEPTH];
    logic [7:0] act_mem [2*DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_expired(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s observed=cycle budget exhausted expected=completion", tag);
    endtask

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_clearing = 0; m_we = 0;
        m_next = 0; m_val = 8'h00; m_count = 8'h00; m_data = 8'h00; m_addr = '0;
    endtask

    task automatic check_all(input string phase);
        check({phase, "_we"},      32'(ram_write_enable), 32'(m_we));
        check({phase, "_addr"},    32'(ram_address),      32'(m_addr));
        check({phase, "_data"},    32'(ram_data_out),     32'(m_data));
        check({phase, "_active"},  32'(active_buffer),    32'(m_active));
        check({phase, "_pending"}, 32'(swap_pending),     32'(m_pending));
        check({phase, "_busy"},    32'(clear_busy),       32'(m_clearing));
        check({phase, "_count"},   32'(cmd_write_count),  32'(m_count));
    endtask

    // One clock of the narrow instance: predict, clock, compare, release pulses.
    task automatic step(input string phase);
        bit was_clearing;
        bit bank;
        was_clearing = m_clearing;
        bank = !m_active;
        m_we = 0;
        if (wr_req) begin
            m_we = 1; m_addr = {bank, wr_addr}; m_data = wr_data; m_count = m_count + 8'd1;
        end else if (m_clearing) begin
            m_we = 1; m_addr = {bank, SAW'(m_next)}; m_data = m_val;
            m_next++;
            if (m_next == DEPTH) m_clearing = 0;
        end
        if (m_we) exp_mem[m_addr] = m_data;
        if (!was_clearing && clear_start) begin
            m_clearing = 1; m_next = 0; m_val = clear_value;
        end
        if (frame_end && (m_pending || swap_req) && !was_clearing) begin
            m_active = !m_active; m_pending = 0;
        end else if (swap_req) begin
            m_pending = 1;
        end
        @(posedge clk_in);
        #1;
        if (ram_write_enable === 1'b1) begin
            act_mem[ram_address] = ram_data_out;
            n_writes++;
            if (verbose)
                $display("[%s] write addr=0x%02h data=0x%02h active=%0d count=%0d",
                         phase, ram_address, ram_data_out, active_buffer, cmd_write_count);
        end
        check_all(phase);
        wr_req = 0; clear_start = 0; swap_req = 0; frame_end = 0;
    endtask

    // Run the model's clear to completion plus one idle cycle.
    task automatic run_clear(input string phase);
        int guard;
        guard = 0;
        while (m_clearing && guard < 200) begin
            step(phase);
            guard++;
        end
        if (m_clearing) bound_expired({phase, "_bound"});
        step(phase);
    endtask

    initial begin
        int w0, guard;
        bit injected;
        reset = 1'b1;
        wr_req = 0; wr_addr = '0; wr_data = '0; clear_start = 0; clear_value = '0;
        swap_req = 0; frame_end = 0;
        b_wr_req = 0; b_wr_addr = '0; b_wr_data = '0;
        model_reset();
        for (int i = 0; i < 2*DEPTH; i++) begin exp_mem[i] = 8'h00; act_mem[i] = 8'h00; end

        // Reset state, before any clock edge
        #1;
        check_all("reset");
        check("reset_wide_addr",   32'(b_ram_address),      32'h0);
        check("reset_wide_we",     32'(b_ram_write_enable), 32'h0);
        check("reset_wide_busy",   32'(b_clear_busy),       32'h0);
        check("reset_wide_active", 32'(b_active_buffer),    32'h0);
        check("reset_wide_pend",   32'(b_swap_pending),     32'h0);
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;

        // Single command write at full width
        b_wr_req = 1; b_wr_addr = 12'h123; b_wr_data = 8'hA5;
        @(posedge clk_in); #1;
        b_wr_req = 0;
        $display("[wide] write addr=0x%04h data=0x%02h count=%0d", b_ram_address, b_ram_data_out, b_cmd_write_count);
        check("wide_addr",  32'(b_ram_address),      32'h1123);
        check("wide_data",  32'(b_ram_data_out),     32'hA5);
        check("wide_we",    32'(b_ram_write_enable), 32'h1);
        check("wide_count", 32'(b_cmd_write_count),  32'h1);
        @(posedge clk_in); #1;
        check("wide_we_drop", 32'(b_ram_write_enable), 32'h0);
        check("wide_addr_hold", 32'(b_ram_address), 32'h1123);

        // Plain clear of the back bank
        w0 = n_writes;
        clear_start = 1; clear_value = 8'h3C;
        step("clr");
        run_clear("clr");
        check("clr_nwrites", 32'(n_writes - w0), 32'd16);

        // Clear with a command write injected at fill address 5
        w0 = n_writes; injected = 0; guard = 0;
        clear_start = 1; clear_value = 8'h3C;
        step("inj");
        while (m_clearing && guard < 200) begin
            if (m_next == 5 && !injected) begin
                wr_req = 1; wr_addr = 4'h7; wr_data = 8'hFF; injected = 1;
            end
            step("inj");
            guard++;
        end
        if (m_clearing) bound_expired("inj_bound");
        step("inj");
        check("inj_nwrites", 32'(n_writes - w0), 32'd17);

        // Swap requested mid-clear waits for the first frame_end after it
        clear_start = 1; clear_value = 8'h5A;
        step("swp");
        step("swp");
        swap_req = 1;
        step("swp");
        guard = 0;
        while (m_clearing && guard < 200) begin
            if (m_next == 8) frame_end = 1;
            step("swp");
            guard++;
        end
        if (m_clearing) bound_expired("swp_bound");
        check("swp_no_toggle_midclear", 32'(active_buffer), 32'h0);
        step("swp");
        step("swp");
        frame_end = 1;
        step("swp");
        check("swp_toggled", 32'(active_buffer), 32'h1);
        check("swp_pending_clr", 32'(swap_pending), 32'h0);
        wr_req = 1; wr_addr = 4'h3; wr_data = 8'h55;
        step("swp");
        check("swp_bank0_addr", 32'(ram_address), 32'h03);

        // Same-cycle swap_req/frame_end, then repeated requests
        swap_req = 1; frame_end = 1;
        step("dbl");
        check("dbl_toggle", 32'(active_buffer), 32'h0);
        for (int i = 0; i < 3; i++) begin
            swap_req = 1;
            step("dbl");
            step("dbl");
        end
        frame_end = 1;
        step("dbl");
        check("dbl_one_toggle", 32'(active_buffer), 32'h1);
        frame_end = 1;
        step("dbl");
        check("dbl_idle_frame_end", 32'(active_buffer), 32'h1);

        // Reset when fill address 9 is next, then restart from address 0
        clear_start = 1; clear_value = 8'h99;
        step("rst");
        guard = 0;
        while (m_next < 9 && guard < 50) begin step("rst"); guard++; end
        #2 reset = 1'b1;
        #1;
        model_reset();
        $display("[rst] asynchronous reset applied mid-clear");
        check_all("rst_async");
        @(posedge clk_in); #1 reset = 1'b0;
        w0 = n_writes;
        clear_start = 1; clear_value = 8'h66;
        step("rst2");
        check("rst2_busy", 32'(clear_busy), 32'h1);
        step("rst2");
        check("rst2_first_addr", 32'(ram_address), 32'h10);
        run_clear("rst2");
        check("rst2_nwrites", 32'(n_writes - w0), 32'd16);

        // Randomized traffic against the model
        verbose = 1'b0;
        for (int i = 0; i < 800; i++) begin
            wr_req      = ($urandom_range(0, 3) == 0);
            wr_addr     = SAW'($urandom_range(0, DEPTH - 1));
            wr_data     = 8'($urandom_range(0, 255));
            clear_start = ($urandom_range(0, 39) == 0);
            clear_value = 8'($urandom_range(0, 255));
            swap_req    = ($urandom_range(0, 15) == 0);
            frame_end   = ($urandom_range(0, 9) == 0);
            step("rnd");
        end
        run_clear("rnd");
        $display("[rnd] random phase done, total writes=%0d", n_writes);

        // RAM image built from observed writes against the model's image
        for (int a = 0; a < 2*DEPTH; a++) begin
            check($sformatf("mem_%02h", a), 32'(act_mem[a]), 32'(exp_mem[a]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
